// File: rtl/data_mem_arbiter.sv
// Arbitrates a single-port synchronous RAM between the CPU data port and a
// second requester (DMA). Each access runs IDLE -> ACC -> RSP, acked on return to IDLE.
module data_mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int CPU_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;
    typedef enum logic {SRC_CPU, SRC_DMA} src_t;

    state_t        state, state_nxt;
    src_t          owner, last_grant, grant_src;
    logic          grant, cpu_elig, dma_elig;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    // A requester seeing its own ack this cycle is finishing, not asking again.
    // Under fixed priority a CPU request held through its ack cycle still
    // outranks DMA, so the slot idles one cycle rather than slipping DMA in.
    always_comb begin
        cpu_elig  = cpu_req && !cpu_ack;
        dma_elig  = dma_req && !dma_ack;
        grant     = 1'b0;
        grant_src = SRC_CPU;
        if (cpu_elig && dma_elig) begin
            grant     = 1'b1;
            grant_src = (CPU_PRIO != 0 || last_grant == SRC_DMA) ? SRC_CPU : SRC_DMA;
        end else if (cpu_elig) begin
            grant = 1'b1;
        end else if (dma_elig && !(CPU_PRIO != 0 && cpu_req)) begin
            grant     = 1'b1;
            grant_src = SRC_DMA;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACC;
            ACC:     state_nxt = RSP;
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= SRC_CPU;
            last_grant <= SRC_DMA;
            acc_we     <= 1'b0;
            acc_addr   <= '0;
            acc_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            state   <= state_nxt;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (state == IDLE && grant) begin
                owner     <= grant_src;
                acc_we    <= (grant_src == SRC_DMA) ? dma_we    : cpu_we;
                acc_addr  <= (grant_src == SRC_DMA) ? dma_addr  : cpu_addr;
                acc_wdata <= (grant_src == SRC_DMA) ? dma_wdata : cpu_wdata;
            end
            // RAM read data is valid during RSP; capture it on the way back to IDLE.
            if (state == RSP) begin
                last_grant <= owner;
                if (owner == SRC_CPU) begin
                    cpu_ack <= 1'b1;
                    if (!acc_we) cpu_rdata <= mem_rdata;
                end else begin
                    dma_ack <= 1'b1;
                    if (!acc_we) dma_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = (state == ACC);
    assign mem_we    = mem_en && acc_we;
    assign mem_addr  = acc_addr;
    assign mem_wdata = acc_wdata;
    assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: round-robin and fixed-priority instances share
// stimulus; checks directed scenarios plus a randomized run against a slot model.
module tb_data_mem_arbiter;
    logic        clk, rst, sel, ram_init;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

    logic [31:0] r_cpu_rdata, r_dma_rdata, r_mem_addr, r_mem_wdata, r_mem_rdata;
    logic        r_cpu_ack, r_cpu_stall, r_dma_ack, r_mem_en, r_mem_we;
    logic [31:0] f_cpu_rdata, f_dma_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic        f_cpu_ack, f_cpu_stall, f_dma_ack, f_mem_en, f_mem_we;

    logic [31:0] obs_cpu_rdata, obs_dma_rdata, obs_mem_addr, obs_mem_wdata;
    logic        obs_cpu_ack, obs_cpu_stall, obs_dma_ack, obs_mem_en, obs_mem_we;

    logic [31:0] ram_r [1024];
    logic [31:0] ram_f [1024];

    int n_chk = 0;
    int n_fail = 0;

    data_mem_arbiter #(.AW(32), .DW(32), .CPU_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(r_cpu_rdata), .cpu_ack(r_cpu_ack), .cpu_stall(r_cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(r_dma_rdata), .dma_ack(r_dma_ack),
        .mem_en(r_mem_en), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
        .mem_rdata(r_mem_rdata)
    );

    data_mem_arbiter #(.AW(32), .DW(32), .CPU_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(f_cpu_rdata), .cpu_ack(f_cpu_ack), .cpu_stall(f_cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(f_dma_rdata), .dma_ack(f_dma_ack),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata)
    );

    assign obs_cpu_rdata = sel ? f_cpu_rdata : r_cpu_rdata;
    assign obs_dma_rdata = sel ? f_dma_rdata : r_dma_rdata;
    assign obs_cpu_ack   = sel ? f_cpu_ack   : r_cpu_ack;
    assign obs_cpu_stall = sel ? f_cpu_stall : r_cpu_stall;
    assign obs_dma_ack   = sel ? f_dma_ack   : r_dma_ack;
    assign obs_mem_en    = sel ? f_mem_en    : r_mem_en;
    assign obs_mem_we    = sel ? f_mem_we    : r_mem_we;
    assign obs_mem_addr  = sel ? f_mem_addr  : r_mem_addr;
    assign obs_mem_wdata = sel ? f_mem_wdata : r_mem_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on RAM contents: word i holds (3*i)/4, so word 0x190 holds 0x12C.
    function automatic logic [31:0] init_val(input int i);
        return 32'((i * 3) >> 2);
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) begin
                ram_r[i] <= init_val(i);
                ram_f[i] <= init_val(i);
            end
        end else begin
            if (r_mem_en) begin
                if (r_mem_we) ram_r[r_mem_addr[9:0]] <= r_mem_wdata;
                else          r_mem_rdata <= ram_r[r_mem_addr[9:0]];
            end
            if (f_mem_en) begin
                if (f_mem_we) ram_f[f_mem_addr[9:0]] <= f_mem_wdata;
                else          f_mem_rdata <= ram_f[f_mem_addr[9:0]];
            end
        end
    end

    // Leaves rst low at posedge+1; caller sets inputs, then releases rst.
    task automatic do_reset(input bit init);
        rst = 1'b0;
        ram_init = init;
        @(posedge clk); #1;
        ram_init = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    task automatic test_reset;
        set_cpu(1, 1, 32'h44, 32'h1234);
        set_dma(1, 0, 32'h88, 32'h0);
        do_reset(1);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            n_chk++;
            if (obs_mem_en !== 1'b0 || obs_mem_we !== 1'b0 || obs_mem_addr !== 32'h0 || obs_mem_wdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_mem inst=%0d got en=%b we=%b addr=%h wdata=%h exp all zero",
                         s, obs_mem_en, obs_mem_we, obs_mem_addr, obs_mem_wdata);
            end
            n_chk++;
            if (obs_cpu_ack !== 1'b0 || obs_dma_ack !== 1'b0 || obs_cpu_rdata !== 32'h0 || obs_dma_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rsp inst=%0d got cack=%b dack=%b crd=%h drd=%h exp all zero",
                         s, obs_cpu_ack, obs_dma_ack, obs_cpu_rdata, obs_dma_rdata);
            end
            n_chk++;
            if (obs_cpu_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_stall inst=%0d got %b exp 1", s, obs_cpu_stall);
            end
        end
        sel = 1'b0;
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read;
        int en_cnt = 0;
        sel = 1'b0;
        do_reset(1);
        set_cpu(1, 0, 32'h190, 32'h0);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (obs_mem_en) en_cnt++;
            if (k == 1) begin
                n_chk++;
                if (obs_mem_en !== 1'b1 || obs_mem_we !== 1'b0 || obs_mem_addr !== 32'h190) begin
                    n_fail++;
                    $display("FAIL cpu_read_acc got en=%b we=%b addr=%h exp 1 0 00000190", obs_mem_en, obs_mem_we, obs_mem_addr);
                end
            end
            n_chk++;
            if (obs_cpu_ack !== (k == 3) || obs_cpu_stall !== (k < 3)) begin
                n_fail++;
                $display("FAIL cpu_read_ack k=%0d got ack=%b stall=%b exp ack=%b stall=%b",
                         k, obs_cpu_ack, obs_cpu_stall, k == 3, k < 3);
            end
            if (k == 3) begin
                n_chk++;
                if (obs_cpu_rdata !== 32'h12C) begin
                    n_fail++;
                    $display("FAIL cpu_read_data got %h exp 0000012c", obs_cpu_rdata);
                end
            end
            @(posedge clk); #1;
            if (k == 3) cpu_req = 1'b0;
        end
        n_chk++;
        if (en_cnt != 1) begin
            n_fail++;
            $display("FAIL cpu_read_single got %0d accesses exp 1", en_cnt);
        end
    endtask

    task automatic test_dma_write;
        int en_cnt = 0;
        sel = 1'b0;
        set_dma(1, 1, 32'h28, 32'hDEADBEEF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (obs_mem_en) en_cnt++;
            if (k == 1) begin
                n_chk++;
                if (obs_mem_en !== 1'b1 || obs_mem_we !== 1'b1 || obs_mem_addr !== 32'h28 || obs_mem_wdata !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL dma_write_acc got en=%b we=%b addr=%h wdata=%h exp 1 1 00000028 deadbeef",
                             obs_mem_en, obs_mem_we, obs_mem_addr, obs_mem_wdata);
                end
            end
            n_chk++;
            if (obs_dma_ack !== (k == 3) || obs_cpu_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL dma_write_ack k=%0d got dack=%b cack=%b exp dack=%b cack=0", k, obs_dma_ack, obs_cpu_ack, k == 3);
            end
            if (k == 5) begin
                n_chk++;
                if (obs_mem_en !== 1'b0 || obs_mem_we !== 1'b0 || obs_mem_addr !== 32'h28 || obs_mem_wdata !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL dma_write_hold got en=%b we=%b addr=%h wdata=%h exp 0 0 00000028 deadbeef",
                             obs_mem_en, obs_mem_we, obs_mem_addr, obs_mem_wdata);
                end
            end
            @(posedge clk); #1;
            if (k == 3) dma_req = 1'b0;
        end
        n_chk++;
        if (ram_r[10'h28] !== 32'hDEADBEEF || en_cnt != 1) begin
            n_fail++;
            $display("FAIL dma_write_ram got ram=%h accesses=%0d exp deadbeef 1", ram_r[10'h28], en_cnt);
        end
        n_chk++;
        if (obs_cpu_rdata !== 32'h12C || obs_dma_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL dma_write_rdata got crd=%h drd=%h exp 0000012c 00000000", obs_cpu_rdata, obs_dma_rdata);
        end
    endtask

    // Both requesters hold req high from reset release onward.
    task automatic test_both_continuous(input bit prio);
        logic exp_c, exp_d;
        sel = prio;
        do_reset(1);
        set_cpu(1, 0, 32'h10, 32'h0);
        set_dma(1, 0, 32'h20, 32'h0);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_c = prio ? (k % 4 == 3) : (k == 3 || k == 9 || k == 15);
            exp_d = prio ? 1'b0 : (k == 6 || k == 12);
            n_chk++;
            if (obs_cpu_ack !== exp_c || obs_dma_ack !== exp_d) begin
                n_fail++;
                $display("FAIL both_cont prio=%0d k=%0d got cack=%b dack=%b exp cack=%b dack=%b",
                         prio, k, obs_cpu_ack, obs_dma_ack, exp_c, exp_d);
            end
            if (exp_c || exp_d) begin
                n_chk++;
                if ((exp_c && obs_cpu_rdata !== init_val(16)) || (exp_d && obs_dma_rdata !== init_val(32))) begin
                    n_fail++;
                    $display("FAIL both_cont_data prio=%0d k=%0d got crd=%h drd=%h exp %h %h",
                             prio, k, obs_cpu_rdata, obs_dma_rdata, init_val(16), init_val(32));
                end
            end
            @(posedge clk); #1;
        end
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_access;
        int acks = 0;
        sel = 1'b0;
        do_reset(1);
        set_cpu(1, 1, 32'h55, 32'hCAFEF00D);
        set_dma(0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++;
        if (obs_mem_en !== 1'b1 || obs_mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre got en=%b we=%b exp 1 1", obs_mem_en, obs_mem_we);
        end
        #1 rst = 1'b0;
        #1;
        n_chk++;
        if (obs_mem_en !== 1'b0 || obs_mem_we !== 1'b0 || obs_mem_addr !== 32'h0 || obs_cpu_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_drop got en=%b we=%b addr=%h ack=%b exp 0 0 0 0",
                     obs_mem_en, obs_mem_we, obs_mem_addr, obs_cpu_ack);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (obs_cpu_ack) acks++;
        end
        n_chk++;
        if (acks != 0 || ram_r[10'h55] !== init_val(32'h55)) begin
            n_fail++;
            $display("FAIL rst_mid_noack got acks=%0d ram=%h exp 0 %h", acks, ram_r[10'h55], init_val(32'h55));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (obs_cpu_ack !== (k == 3)) begin
                n_fail++;
                $display("FAIL rst_mid_retry k=%0d got ack=%b exp %b", k, obs_cpu_ack, k == 3);
            end
            @(posedge clk); #1;
            if (k == 3) cpu_req = 1'b0;
        end
        n_chk++;
        if (ram_r[10'h55] !== 32'hCAFEF00D || obs_cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_write got ram=%h crd=%h exp cafef00d 00000000", ram_r[10'h55], obs_cpu_rdata);
        end
    endtask

    // Slot model: the memory is free at cycle free_at; a grant at t occupies
    // t+1 (access) and t+2 (response) and is acked in t+3, when the slot is free again.
    task automatic test_random(input bit prio, input int ncyc);
        logic [31:0] ref_mem [1024];
        logic [31:0] exp_rd [2];
        int          ack_at [2];
        int          free_at, acc_at, g, grants, en_seen;
        bit          last_dma, ea_c, ea_d, ec, ed, exp_en;
        bit          own_dma, own_we;
        logic [31:0] own_addr, own_wdata, pend_rd;
        logic        nc_req, nc_we, nd_req, nd_we;
        logic [31:0] nc_addr, nc_wdata, nd_addr, nd_wdata;

        sel = prio;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        do_reset(1);
        rst = 1'b1;
        free_at = 0; acc_at = -1; ack_at[0] = -1; ack_at[1] = -1;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        last_dma = 1'b1; own_dma = 1'b0; own_we = 1'b0;
        own_addr = 32'h0; own_wdata = 32'h0; pend_rd = 32'h0;
        grants = 0; en_seen = 0;

        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            ea_c = (ack_at[0] == t);
            ea_d = (ack_at[1] == t);
            if (ea_c || ea_d) begin
                last_dma = ea_d;
                if (!own_we) exp_rd[own_dma] = pend_rd;
            end
            n_chk++;
            if (obs_cpu_ack !== ea_c || obs_dma_ack !== ea_d) begin
                n_fail++;
                $display("FAIL rand_ack prio=%0d t=%0d got cack=%b dack=%b exp cack=%b dack=%b",
                         prio, t, obs_cpu_ack, obs_dma_ack, ea_c, ea_d);
            end
            n_chk++;
            if (obs_cpu_rdata !== exp_rd[0] || obs_dma_rdata !== exp_rd[1]) begin
                n_fail++;
                $display("FAIL rand_rdata prio=%0d t=%0d got crd=%h drd=%h exp %h %h",
                         prio, t, obs_cpu_rdata, obs_dma_rdata, exp_rd[0], exp_rd[1]);
            end
            n_chk++;
            if (obs_cpu_stall !== (cpu_req && !ea_c)) begin
                n_fail++;
                $display("FAIL rand_stall prio=%0d t=%0d got %b exp %b", prio, t, obs_cpu_stall, cpu_req && !ea_c);
            end
            exp_en = (acc_at == t);
            n_chk++;
            if (obs_mem_en !== exp_en || obs_mem_we !== (exp_en && own_we) ||
                (grants > 0 && (obs_mem_addr !== own_addr || obs_mem_wdata !== own_wdata))) begin
                n_fail++;
                $display("FAIL rand_mem prio=%0d t=%0d got en=%b we=%b addr=%h wd=%h exp en=%b we=%b addr=%h wd=%h",
                         prio, t, obs_mem_en, obs_mem_we, obs_mem_addr, obs_mem_wdata,
                         exp_en, exp_en && own_we, own_addr, own_wdata);
            end
            if (obs_mem_en) en_seen++;

            if (t >= free_at) begin
                ec = cpu_req && !ea_c;
                ed = dma_req && !ea_d;
                g  = -1;
                if (ec && ed)                      g = (prio || last_dma) ? 0 : 1;
                else if (ec)                       g = 0;
                else if (ed && !(prio && cpu_req)) g = 1;
                if (g >= 0) begin
                    own_dma   = (g == 1);
                    own_we    = own_dma ? dma_we    : cpu_we;
                    own_addr  = own_dma ? dma_addr  : cpu_addr;
                    own_wdata = own_dma ? dma_wdata : cpu_wdata;
                    if (own_we) ref_mem[own_addr[9:0]] = own_wdata;
                    else        pend_rd = ref_mem[own_addr[9:0]];
                    acc_at    = t + 1;
                    ack_at[g] = t + 3;
                    free_at   = t + 3;
                    grants++;
                end
            end

            nc_req = cpu_req; nc_we = cpu_we; nc_addr = cpu_addr; nc_wdata = cpu_wdata;
            nd_req = dma_req; nd_we = dma_we; nd_addr = dma_addr; nd_wdata = dma_wdata;
            if (ea_c || !cpu_req) begin
                nc_req   = ($urandom_range(0, 2) != 0);
                nc_we    = 1'($urandom_range(0, 1));
                nc_addr  = 32'($urandom_range(0, 1023));
                nc_wdata = $urandom;
            end
            if (ea_d || !dma_req) begin
                nd_req   = ($urandom_range(0, 2) != 0);
                nd_we    = 1'($urandom_range(0, 1));
                nd_addr  = 32'($urandom_range(0, 1023));
                nd_wdata = $urandom;
            end
            @(posedge clk); #1;
            set_cpu(nc_req, nc_we, nc_addr, nc_wdata);
            set_dma(nd_req, nd_we, nd_addr, nd_wdata);
        end
        n_chk++;
        if (en_seen != grants || grants < 20) begin
            n_fail++;
            $display("FAIL rand_access_count prio=%0d got %0d accesses exp %0d (at least 20)", prio, en_seen, grants);
        end
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; ram_init = 1'b0;
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_both_continuous(1'b0);
        test_both_continuous(1'b1);
        test_reset_mid_access();
        test_random(1'b0, 400);
        test_random(1'b1, 400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter CPU_PRIO, default 0: 0 selects round-robin; 1 selects fixed CPU priority.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cpu_req / cpu_we  in  1 / 1  processor data-port access request and write enable.
REQ-007 cpu_addr / cpu_wdata  in  AW / DW  processor address and write data.
REQ-008 cpu_rdata / cpu_ack / cpu_stall  out  DW / 1 / 1  read data, one-cycle completion pulse, pipeline stall.
REQ-009 dma_req / dma_we / dma_addr / dma_wdata  in  1 / 1 / AW / DW  second-requester (loader/display) access.
REQ-010 dma_rdata / dma_ack  out  DW / 1  second-requester read data and completion pulse.
REQ-011 mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / AW / DW  single-port synchronous RAM controls.
REQ-012 mem_rdata  in  DW  RAM read data, valid one cycle after a cycle with mem_en=1 and mem_we=0.

Function
REQ-013 Requester holds req, we, addr and wdata stable from req rise until its ack cycle, then drops or re-requests.
REQ-014 FSM states IDLE, ACC, RSP; transitions IDLE->ACC on a granted request, ACC->RSP always, RSP->IDLE always.
REQ-015 In IDLE a requester whose ack is high in that cycle is ignored, so a held req never causes a duplicate access.
REQ-016 IDLE with one eligible request: grant it, latch owner, we, addr, wdata.
REQ-017 IDLE with both eligible, CPU_PRIO=0: grant the requester not granted last; the last_grant register resets to DMA, so CPU wins the first tie.
REQ-018 IDLE with both eligible, CPU_PRIO=1: always grant CPU.
REQ-019 In ACC: mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values.
REQ-020 Outside ACC: mem_en=0, mem_we=0, mem_addr/mem_wdata hold the last latched values.
REQ-021 RSP->IDLE edge, read: owner rdata register loads mem_rdata; non-owner rdata unchanged.
REQ-022 RSP->IDLE edge, write: both rdata registers unchanged.
REQ-023 RSP->IDLE edge, any access: owner ack register set for exactly one cycle; last_grant updated to the owner.
REQ-024 Latency: request sampled in IDLE cycle N -> mem_en in N+1 -> ack and valid rdata in N+3; throughput one access per 3 cycles.
REQ-025 Starvation bound, CPU_PRIO=0: a continuously requesting requester is acked within 6 cycles of its first IDLE sample.
REQ-026 cpu_stall = cpu_req AND NOT cpu_ack, combinational.
REQ-027 A request arriving during ACC or RSP waits for the next IDLE; it is never lost.
REQ-028 Addresses pass through unmodified; width conversion is not performed in this block.

Reset
REQ-029 While rst=0: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 While rst=0: cpu_ack=0, dma_ack=0, cpu_rdata=0, dma_rdata=0, last_grant=DMA.
REQ-031 Reset asserted mid-transaction drops the access with no ack; the requester re-requests after reset release.
REQ-032 First IDLE sample occurs on the first rising edge after rst rises.

Verification
REQ-033 CPU read alone, addr=0x190, RAM[0x190]=0x12C -> mem_en high one cycle with mem_we=0; cpu_ack high 3 cycles after sample; cpu_rdata=0x12C; cpu_stall low in the ack cycle.
REQ-034 DMA write alone, addr=0x28, wdata=0xDEADBEEF -> one cycle mem_en=1, mem_we=1; dma_ack pulse; RAM[0x28]=0xDEADBEEF; both rdata unchanged.
REQ-035 Both requesting continuously, CPU_PRIO=0, from reset -> grants CPU,DMA,CPU,DMA; acks every 3 cycles alternating.
REQ-036 Same stimulus with CPU_PRIO=1 -> four consecutive CPU acks, no DMA ack.
REQ-037 Requester holds req through its ack cycle, then drops it -> exactly one mem_en per request; no duplicate access.
REQ-038 rst driven low during ACC of a CPU write -> mem_en=0 immediately, no cpu_ack; after release, a re-request completes normally.
